// File: rtl/pconv_feeder_pkg.sv
// Shared definitions for the pointwise-conv feeder: FSM state encoding and the
// bias/shift operand widths common to the conv unit interface.
package pconv_feeder_pkg;

    localparam int BIAS_W  = 32;
    localparam int SHIFT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        LD_W,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    // Address width that never collapses to zero bits for single-entry ranges.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pconv_feeder_ctrl.sv
// Sequencer for the feeder: per output channel it fetches parameters once, then
// streams every pixel address, producing read strobes and an issue strobe with tags.
module pconv_feeder_ctrl
    import pconv_feeder_pkg::*;
#(
    parameter int OUTPUT_CHANNEL = 8,
    parameter int PIXELS         = 64,
    localparam int PW = addr_w(PIXELS),
    localparam int CW = addr_w(OUTPUT_CHANNEL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    output logic          busy,
    output logic          done,
    output logic          fmap_rd_en,
    output logic [PW-1:0] fmap_addr,
    output logic          wt_rd_en,
    output logic [CW-1:0] wt_addr,
    output logic          ld_w,
    output logic          issue,
    output logic [CW-1:0] issue_ch,
    output logic [PW-1:0] issue_pix
);

    localparam logic [PW-1:0] P_LAST  = PW'(PIXELS - 1);
    localparam logic [CW-1:0] OC_LAST = CW'(OUTPUT_CHANNEL - 1);

    feeder_state_t state;
    feeder_state_t state_next;
    logic [CW-1:0] oc;
    logic [PW-1:0] p;

    // Counters saturate at their last index; the FSM leaves STREAM/DRAIN there.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            oc    <= '0;
            p     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE:    if (start) oc <= '0;
                LD_W:    p <= '0;
                STREAM:  if (!pause && (p != P_LAST)) p <= p + 1'b1;
                DRAIN:   if (oc != OC_LAST) oc <= oc + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        fmap_rd_en = 1'b0;
        wt_rd_en   = 1'b0;
        ld_w       = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RD_W;
            RD_W: begin
                wt_rd_en   = 1'b1;
                state_next = LD_W;
            end
            LD_W: begin
                ld_w       = 1'b1;
                state_next = STREAM;
            end
            STREAM: if (!pause) begin
                fmap_rd_en = 1'b1;
                issue      = 1'b1;
                if (p == P_LAST) state_next = DRAIN;
            end
            DRAIN: state_next = (oc == OC_LAST) ? DONE : RD_W;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign fmap_addr = p;
    assign wt_addr   = oc;
    assign issue_ch  = oc;
    assign issue_pix = p;

endmodule

// File: rtl/pconv_feeder.sv
// Pointwise-conv operand feeder: walks output channels over pixels and presents
// aligned feature/weight/bias/shift operands with (channel, pixel) tags.
module pconv_feeder
    import pconv_feeder_pkg::*;
#(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 8,
    parameter int PIXELS         = 64,
    localparam int PW = addr_w(PIXELS),
    localparam int CW = addr_w(OUTPUT_CHANNEL),
    localparam int DW = INPUT_CHANNEL * N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    output logic               busy,
    output logic               done,
    output logic               fmap_rd_en,
    output logic [PW-1:0]      fmap_addr,
    input  logic [DW-1:0]      fmap_rdata,
    output logic               wt_rd_en,
    output logic [CW-1:0]      wt_addr,
    input  logic [DW-1:0]      wt_rdata,
    input  logic [BIAS_W-1:0]  bias_rdata,
    input  logic [SHIFT_W-1:0] shift_rdata,
    output logic               input_vld,
    output logic [DW-1:0]      input_din,
    output logic [DW-1:0]      weight_din,
    output logic [BIAS_W-1:0]  bias_din,
    output logic [SHIFT_W-1:0] shift_din,
    output logic [CW-1:0]      tag_ch,
    output logic [PW-1:0]      tag_pix
);

    logic          ld_w;
    logic          issue;
    logic [CW-1:0] issue_ch;
    logic [PW-1:0] issue_pix;

    logic          vld_q;
    logic [CW-1:0] ch_q;
    logic [PW-1:0] pix_q;

    pconv_feeder_ctrl #(
        .OUTPUT_CHANNEL(OUTPUT_CHANNEL),
        .PIXELS        (PIXELS)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .busy      (busy),
        .done      (done),
        .fmap_rd_en(fmap_rd_en),
        .fmap_addr (fmap_addr),
        .wt_rd_en  (wt_rd_en),
        .wt_addr   (wt_addr),
        .ld_w      (ld_w),
        .issue     (issue),
        .issue_ch  (issue_ch),
        .issue_pix (issue_pix)
    );

    // Stage 1 follows the RAM read latency; stage 2 captures the returned data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_q     <= 1'b0;
            ch_q      <= '0;
            pix_q     <= '0;
            input_vld <= 1'b0;
            input_din <= '0;
            tag_ch    <= '0;
            tag_pix   <= '0;
        end else begin
            vld_q     <= issue;
            input_vld <= vld_q;
            if (issue) begin
                ch_q  <= issue_ch;
                pix_q <= issue_pix;
            end
            if (vld_q) begin
                input_din <= fmap_rdata;
                tag_ch    <= ch_q;
                tag_pix   <= pix_q;
            end
        end
    end

    // Parameters change only after the previous channel's last operand has left.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            weight_din <= '0;
            bias_din   <= '0;
            shift_din  <= '0;
        end else if (ld_w) begin
            weight_din <= wt_rdata;
            bias_din   <= bias_rdata;
            shift_din  <= shift_rdata;
        end
    end

endmodule

// File: tb/tb_pconv_feeder.sv
// Scoreboard bench for pconv_feeder: three instances (2x4, 1x1, 8x64) driven by
// directed stimulus; a negedge monitor pops expected operands and compares.
`timescale 1ns/1ps
module tb_pconv_feeder;

    localparam int DW = 48;
    localparam logic [DW-1:0] POISON = {3{16'hDEAD}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_count = 0;
    int fail_count = 0;

    typedef struct {
        int              cyc;
        int              ch;
        int              pix;
        logic [DW-1:0]   din;
        logic [DW-1:0]   wt;
        logic [31:0]     bias;
        logic [4:0]      shift;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   da[$];
    int   db[$];
    int   dc[$];

    int t0 = 1 << 30;
    int final_rel = -1;
    int zero_rel = -1;
    int exp_vld = 0;
    int vld_cnt = 0;
    int rel = 0;
    int blo1[3];
    int bhi1[3];
    int blo2[3];
    int bhi2[3];

    logic [DW-1:0] fm_mem[64];
    logic [DW-1:0] wt_mem[8];
    logic [31:0]   bias_mem[8];
    logic [4:0]    shift_mem[8];

    logic rst_a, rst_bc, bc_pause;

    // ---------------- instance A: 2 channels x 4 pixels ----------------
    logic          a_start, a_pause, a_busy, a_done, a_fmap_rd_en, a_wt_rd_en, a_input_vld;
    logic [1:0]    a_fmap_addr, a_tag_pix;
    logic [0:0]    a_wt_addr, a_tag_ch;
    logic [DW-1:0] a_fmap_rdata, a_wt_rdata, a_input_din, a_weight_din;
    logic [31:0]   a_bias_rdata, a_bias_din;
    logic [4:0]    a_shift_rdata, a_shift_din;

    pconv_feeder #(.N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(2), .PIXELS(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .start(a_start), .pause(a_pause),
        .busy(a_busy), .done(a_done),
        .fmap_rd_en(a_fmap_rd_en), .fmap_addr(a_fmap_addr), .fmap_rdata(a_fmap_rdata),
        .wt_rd_en(a_wt_rd_en), .wt_addr(a_wt_addr), .wt_rdata(a_wt_rdata),
        .bias_rdata(a_bias_rdata), .shift_rdata(a_shift_rdata),
        .input_vld(a_input_vld), .input_din(a_input_din), .weight_din(a_weight_din),
        .bias_din(a_bias_din), .shift_din(a_shift_din),
        .tag_ch(a_tag_ch), .tag_pix(a_tag_pix)
    );

    // ---------------- instance B: 1 channel x 1 pixel ----------------
    logic          b_start, b_busy, b_done, b_fmap_rd_en, b_wt_rd_en, b_input_vld;
    logic [0:0]    b_fmap_addr, b_tag_pix, b_wt_addr, b_tag_ch;
    logic [DW-1:0] b_fmap_rdata, b_wt_rdata, b_input_din, b_weight_din;
    logic [31:0]   b_bias_rdata, b_bias_din;
    logic [4:0]    b_shift_rdata, b_shift_din;

    pconv_feeder #(.N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(1), .PIXELS(1)) dut_b (
        .clk(clk), .rst_n(rst_bc), .start(b_start), .pause(bc_pause),
        .busy(b_busy), .done(b_done),
        .fmap_rd_en(b_fmap_rd_en), .fmap_addr(b_fmap_addr), .fmap_rdata(b_fmap_rdata),
        .wt_rd_en(b_wt_rd_en), .wt_addr(b_wt_addr), .wt_rdata(b_wt_rdata),
        .bias_rdata(b_bias_rdata), .shift_rdata(b_shift_rdata),
        .input_vld(b_input_vld), .input_din(b_input_din), .weight_din(b_weight_din),
        .bias_din(b_bias_din), .shift_din(b_shift_din),
        .tag_ch(b_tag_ch), .tag_pix(b_tag_pix)
    );

    // ---------------- instance C: 8 channels x 64 pixels ----------------
    logic          c_start, c_busy, c_done, c_fmap_rd_en, c_wt_rd_en, c_input_vld;
    logic [5:0]    c_fmap_addr, c_tag_pix;
    logic [2:0]    c_wt_addr, c_tag_ch;
    logic [DW-1:0] c_fmap_rdata, c_wt_rdata, c_input_din, c_weight_din;
    logic [31:0]   c_bias_rdata, c_bias_din;
    logic [4:0]    c_shift_rdata, c_shift_din;

    pconv_feeder #(.N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(8), .PIXELS(64)) dut_c (
        .clk(clk), .rst_n(rst_bc), .start(c_start), .pause(bc_pause),
        .busy(c_busy), .done(c_done),
        .fmap_rd_en(c_fmap_rd_en), .fmap_addr(c_fmap_addr), .fmap_rdata(c_fmap_rdata),
        .wt_rd_en(c_wt_rd_en), .wt_addr(c_wt_addr), .wt_rdata(c_wt_rdata),
        .bias_rdata(c_bias_rdata), .shift_rdata(c_shift_rdata),
        .input_vld(c_input_vld), .input_din(c_input_din), .weight_din(c_weight_din),
        .bias_din(c_bias_din), .shift_din(c_shift_din),
        .tag_ch(c_tag_ch), .tag_pix(c_tag_pix)
    );

    function automatic logic [DW-1:0] lanes(input logic [15:0] v);
        return {v, v, v};
    endfunction

    // Memory models: one-cycle read latency, poison data when not read.
    always @(posedge clk) begin
        a_fmap_rdata  <= a_fmap_rd_en ? lanes(16'h0010 + 16'(a_fmap_addr)) : POISON;
        a_wt_rdata    <= a_wt_rd_en ? lanes(16'h0100 + 16'(a_wt_addr)) : POISON;
        a_bias_rdata  <= a_wt_rd_en ? 32'h1000 + 32'(a_wt_addr) : 32'hDEADBEEF;
        a_shift_rdata <= a_wt_rd_en ? 5'd3 + 5'(a_wt_addr) : 5'h1F;
        b_fmap_rdata  <= b_fmap_rd_en ? lanes(16'h0010 + 16'(b_fmap_addr)) : POISON;
        b_wt_rdata    <= b_wt_rd_en ? lanes(16'h0100 + 16'(b_wt_addr)) : POISON;
        b_bias_rdata  <= b_wt_rd_en ? 32'h1000 + 32'(b_wt_addr) : 32'hDEADBEEF;
        b_shift_rdata <= b_wt_rd_en ? 5'd3 + 5'(b_wt_addr) : 5'h1F;
        c_fmap_rdata  <= c_fmap_rd_en ? fm_mem[c_fmap_addr] : POISON;
        c_wt_rdata    <= c_wt_rd_en ? wt_mem[c_wt_addr] : POISON;
        c_bias_rdata  <= c_wt_rd_en ? bias_mem[c_wt_addr] : 32'hDEADBEEF;
        c_shift_rdata <= c_wt_rd_en ? shift_mem[c_wt_addr] : 5'h1F;
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        cmp_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (rel cycle %0d)", name, got, want, rel);
        end
    endtask

    task automatic checkOp(input int which, input string nm, input logic vld, input logic dn,
                           input logic bsy, input int ch, input int pix,
                           input logic [DW-1:0] din, input logic [DW-1:0] wt,
                           input logic [31:0] bias, input logic [4:0] shift);
        exp_t e;
        int   dcyc;
        bit   have;
        bit   want_busy;
        if (vld) begin
            have = 1'b0;
            if (which == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
            if (which == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
            if (which == 2 && qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
            checkOutput({nm, "_vld_expected"}, 64'(have), 64'd1);
            if (have) begin
                checkOutput({nm, "_vld_cycle"}, 64'(rel), 64'(e.cyc));
                checkOutput({nm, "_tag_ch"}, 64'(ch), 64'(e.ch));
                checkOutput({nm, "_tag_pix"}, 64'(pix), 64'(e.pix));
                checkOutput({nm, "_input_din"}, 64'(din), 64'(e.din));
                checkOutput({nm, "_weight_din"}, 64'(wt), 64'(e.wt));
                checkOutput({nm, "_bias_din"}, 64'(bias), 64'(e.bias));
                checkOutput({nm, "_shift_din"}, 64'(shift), 64'(e.shift));
            end
        end
        if (dn) begin
            have = 1'b0;
            if (which == 0 && da.size() > 0) begin dcyc = da.pop_front(); have = 1'b1; end
            if (which == 1 && db.size() > 0) begin dcyc = db.pop_front(); have = 1'b1; end
            if (which == 2 && dc.size() > 0) begin dcyc = dc.pop_front(); have = 1'b1; end
            checkOutput({nm, "_done_expected"}, 64'(have), 64'd1);
            if (have) checkOutput({nm, "_done_cycle"}, 64'(rel), 64'(dcyc));
        end
        want_busy = ((rel >= blo1[which]) && (rel <= bhi1[which])) ||
                    ((rel >= blo2[which]) && (rel <= bhi2[which]));
        checkOutput({nm, "_busy"}, 64'(bsy), 64'(want_busy));
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        rel = cyc - t0;
        if (rel == 0) vld_cnt = 0;
        vld_cnt = vld_cnt + int'(a_input_vld) + int'(b_input_vld) + int'(c_input_vld);
        checkOp(0, "a", a_input_vld, a_done, a_busy, int'(a_tag_ch), int'(a_tag_pix),
                a_input_din, a_weight_din, a_bias_din, a_shift_din);
        checkOp(1, "b", b_input_vld, b_done, b_busy, int'(b_tag_ch), int'(b_tag_pix),
                b_input_din, b_weight_din, b_bias_din, b_shift_din);
        checkOp(2, "c", c_input_vld, c_done, c_busy, int'(c_tag_ch), int'(c_tag_pix),
                c_input_din, c_weight_din, c_bias_din, c_shift_din);
        checkOutput("rd_en_exclusive", 64'(a_fmap_rd_en & a_wt_rd_en), 64'd0);
        if (rel == zero_rel) begin
            checkOutput("a_zero_vld", 64'(a_input_vld), 64'd0);
            checkOutput("a_zero_done", 64'(a_done), 64'd0);
            checkOutput("a_zero_busy", 64'(a_busy), 64'd0);
            checkOutput("a_zero_rd", 64'({a_fmap_rd_en, a_wt_rd_en}), 64'd0);
            checkOutput("a_zero_addr", 64'({a_fmap_addr, a_wt_addr}), 64'd0);
            checkOutput("a_zero_din", 64'(a_input_din), 64'd0);
            checkOutput("a_zero_weight", 64'(a_weight_din), 64'd0);
            checkOutput("a_zero_bias", 64'(a_bias_din), 64'd0);
            checkOutput("a_zero_shift", 64'(a_shift_din), 64'd0);
            checkOutput("a_zero_tags", 64'({a_tag_ch, a_tag_pix}), 64'd0);
        end
        if (rel == final_rel) begin
            checkOutput("vld_count", 64'(vld_cnt), 64'(exp_vld));
            checkOutput("ops_left", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
            checkOutput("done_left", 64'(da.size() + db.size() + dc.size()), 64'd0);
        end
    end

    task automatic expectOp(input int which, input int c, input int ch, input int pix);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.pix = pix;
        if (which == 2) begin
            e.din   = fm_mem[pix];
            e.wt    = wt_mem[ch];
            e.bias  = bias_mem[ch];
            e.shift = shift_mem[ch];
        end else begin
            e.din   = lanes(16'(32'h10 + pix));
            e.wt    = lanes(16'(32'h100 + ch));
            e.bias  = 32'(32'h1000 + ch);
            e.shift = 5'(3 + ch);
        end
        if (which == 0) qa.push_back(e);
        else if (which == 1) qb.push_back(e);
        else qc.push_back(e);
    endtask

    task automatic expectChannel(input int which, input int ch, input int first, input int npix);
        for (int p = 0; p < npix; p++) expectOp(which, first + p, ch, p);
    endtask

    task automatic setBusy(input int which, input int lo1, input int hi1, input int lo2, input int hi2);
        for (int i = 0; i < 3; i++) begin
            blo1[i] = -1; bhi1[i] = -2; blo2[i] = -1; bhi2[i] = -2;
        end
        blo1[which] = lo1; bhi1[which] = hi1;
        blo2[which] = lo2; bhi2[which] = hi2;
    endtask

    // Drives one test window; cycle 0 of the window is the reference for expectations.
    task automatic applyStimulus(input int which, input int len, input int s0, input int s1,
                                 input int s2, input int plo, input int phi, input int rc);
        bit hit;
        final_rel = len - 1;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) t0 = cyc;
            hit     = (k == s0) || (k == s1) || (k == s2);
            a_start = (which == 0) && hit;
            b_start = (which == 1) && hit;
            c_start = (which == 2) && hit;
            a_pause = (which == 0) && (k >= plo) && (k <= phi);
            rst_a   = (which == 0) && (k == rc);
        end
        @(posedge clk);
        #1;
        t0 = 1 << 30;
        a_start = 0; b_start = 0; c_start = 0; a_pause = 0; rst_a = 0;
        zero_rel = -1;
    endtask

    initial begin
        rst_a = 1; rst_bc = 1; bc_pause = 0;
        a_start = 0; a_pause = 0; b_start = 0; c_start = 0;
        setBusy(0, -1, -2, -1, -2);
        for (int i = 0; i < 64; i++) fm_mem[i] = {16'($urandom), 32'($urandom)};
        for (int i = 0; i < 8; i++) begin
            wt_mem[i]    = {16'($urandom), 32'($urandom)};
            bias_mem[i]  = $urandom;
            shift_mem[i] = 5'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_a = 0; rst_bc = 0;
        repeat (2) @(posedge clk);

        $display("[TB] test 1: plain pass, reset state at cycle 0");
        expectChannel(0, 0, 5, 4);
        expectChannel(0, 1, 12, 4);
        da.push_back(15);
        setBusy(0, 1, 15, -1, -2);
        exp_vld = 8; zero_rel = 0;
        applyStimulus(0, 20, 0, -1, -1, -1, -1, -1);

        $display("[TB] test 2: pause in cycles 4-5");
        expectOp(0, 5, 0, 0);
        expectOp(0, 8, 0, 1);
        expectOp(0, 9, 0, 2);
        expectOp(0, 10, 0, 3);
        expectChannel(0, 1, 14, 4);
        da.push_back(17);
        setBusy(0, 1, 17, -1, -2);
        exp_vld = 8;
        applyStimulus(0, 22, 0, -1, -1, 4, 5, -1);

        $display("[TB] test 3: reset in cycle 7, restart in cycle 10");
        expectChannel(0, 0, 5, 3);
        expectChannel(0, 0, 15, 4);
        expectChannel(0, 1, 22, 4);
        da.push_back(25);
        setBusy(0, 1, 7, 11, 25);
        exp_vld = 11; zero_rel = 8;
        applyStimulus(0, 30, 0, 10, -1, -1, -1, 7);

        $display("[TB] test 4: extra start pulses in cycles 3 and 9");
        expectChannel(0, 0, 5, 4);
        expectChannel(0, 1, 12, 4);
        da.push_back(15);
        setBusy(0, 1, 15, -1, -2);
        exp_vld = 8;
        applyStimulus(0, 20, 0, 3, 9, -1, -1, -1);

        $display("[TB] test 5: single channel, single pixel");
        expectOp(1, 5, 0, 0);
        db.push_back(5);
        setBusy(1, 1, 5, -1, -2);
        exp_vld = 1;
        applyStimulus(1, 10, 0, -1, -1, -1, -1, -1);

        $display("[TB] test 6: 8x64 random contents");
        for (int ch = 0; ch < 8; ch++) expectChannel(2, ch, ch * 67 + 5, 64);
        dc.push_back(8 * 67 + 1);
        setBusy(2, 1, 8 * 67 + 1, -1, -2);
        exp_vld = 512;
        applyStimulus(2, 540, 0, -1, -1, -1, -1, -1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
